reg_writeback_arbiter: RTL and testbench
========================================

// Module: reg_writeback_arbiter
// PURPOSE
//   Write side of the 32-entry register file in the decode stage. Merges W-stage results with
//   long-latency results (load-miss / mul-div unit) onto the single write port (write_enable, a3, wd3).
//   Long-latency results are buffered in an in-order FIFO. Pipeline results win the port by default.
//   A starvation counter requests a one-cycle W-stage bubble so that buffered results drain.
// PARAMETERS
//   DATA_WIDTH   32  width of register data
//   FIFO_DEPTH   4   long-latency result buffer entries; power of 2, >=2
//   STARVE_LIMIT 8   consecutive lost-arbitration cycles before stall_req; >=1
// PORTS
//   clk          in   1              rising-edge clock
//   rst          in   1              synchronous, active-high reset
//   pipe_we      in   1              W-stage result valid this cycle (no backpressure)
//   pipe_rd      in   5              W-stage destination register
//   pipe_wd      in   DATA_WIDTH     W-stage result data
//   mc_valid     in   1              long-latency result offered
//   mc_ready     out  1              FIFO can accept; transfer when mc_valid && mc_ready
//   mc_rd        in   5              long-latency destination register
//   mc_wd        in   DATA_WIDTH     long-latency result data
//   write_enable out  1              register-file write strobe (registered)
//   a3           out  5              register-file write address (registered)
//   wd3          out  DATA_WIDTH     register-file write data (registered)
//   stall_req    out  1              hazard unit must bubble W this cycle (pipe_we=0)
//   fifo_count   out  $clog2(FIFO_DEPTH)+1  entries currently buffered
// BEHAVIOUR
//   - Reset values: write_enable=0, a3=0, wd3=0, fifo_count=0, stall_req=0, FIFO empty, starve_cnt=0.
//     mc_ready=0 while rst=1. Reset mid-operation discards all buffered entries. No write is issued
//     in the reset cycle or the cycle after.
//   - mc_ready = !rst && (fifo_count != FIFO_DEPTH). It depends only on state and never on mc_valid.
//   - Accept: mc_valid && mc_ready. If mc_rd!=0, push {mc_rd, mc_wd} at the tail. If mc_rd==0, the
//     transfer completes but nothing is enqueued (x0 writes are dropped).
//   - Arbitration each cycle, selecting at most one source:
//       1. stall_req=1 && FIFO nonempty: pop head.
//       2. pipe_we && pipe_rd!=0: pipeline wins.
//       3. FIFO nonempty: pop head.
//       4. Otherwise idle.
//   - The selected source is registered onto {write_enable=1, a3, wd3} at the next edge: 1-cycle latency.
//     If nothing is selected, write_enable=0 and a3/wd3 hold their previous values.
//   - pipe_we with pipe_rd==0 is not a write: no port use, FIFO may pop that cycle.
//   - Push and pop in the same cycle: count unchanged, head/tail advance. A pop and a push to a 1-entry
//     FIFO are legal; the pushed entry is never popped in its own push cycle.
//   - Full: mc_ready=0. A pop while full does not raise mc_ready until the next cycle.
//   - Pointers wrap modulo FIFO_DEPTH; fifo_count is a separate up/down counter.
//   - Minimum mc-to-regfile latency is 2 cycles: push at edge N, pop selected in cycle N, write_enable high after edge N+1.
//   - starve_cnt: increments when FIFO is nonempty and the pipeline wins; cleared on any pop or when the
//     FIFO is empty; saturates at STARVE_LIMIT. stall_req = (starve_cnt==STARVE_LIMIT).
//   - If pipe_we && pipe_rd!=0 while stall_req=1, it is a contract violation: the FIFO still wins and the
//     pipe write is dropped. The bench flags this as an error.
//   - WAW ordering between the FIFO and the pipeline is the issue logic's responsibility. FIFO entries retire in order.
// TESTING
//   1. rst 3 cycles, then pipe_we=1, rd=5, wd=0xDEADBEEF -> next cycle we=1, a3=5, wd3=0xDEADBEEF; regs reset-valued during rst.
//   2. Idle pipe; mc push rd=7, wd=0x11 -> fifo_count=1, then we=1, a3=7, wd3=0x11 two edges after accept; count returns to 0.
//   3. Pipe writes rd=1 every cycle; push 4 mc entries -> mc_ready=0 at count 4; stall_req high after 8 lost cycles;
//      pipe_we=0 that cycle -> head pops, stall_req clears, count=3.
//   4. Push mc rd=0, wd=0xFF -> transfer accepted, fifo_count stays 0, no register write.
//   5. pipe_we=1, pipe_rd=0 with FIFO holding rd=9 -> FIFO entry written (a3=9) next cycle.
//   6. rst asserted with 3 entries buffered -> fifo_count=0, mc_ready=0; after release, no stale writes occur and mc_ready=1.

Source files
------------

// File: rtl/reg_writeback_arbiter.sv
// Register-file write-port arbiter: W-stage results win by default, long-latency results
// are queued in order and drained when the port is free or after a starvation bubble.
module reg_writeback_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           pipe_we,
    input  logic [4:0]                     pipe_rd,
    input  logic [DATA_WIDTH-1:0]          pipe_wd,
    input  logic                           mc_valid,
    output logic                           mc_ready,
    input  logic [4:0]                     mc_rd,
    input  logic [DATA_WIDTH-1:0]          mc_wd,
    output logic                           write_enable,
    output logic [4:0]                     a3,
    output logic [DATA_WIDTH-1:0]          wd3,
    output logic                           stall_req,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [4:0]            r_fifo_rd [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_fifo_wd [FIFO_DEPTH];
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [CW-1:0]         r_count;
    logic [SW-1:0]         r_starve;
    logic                  r_we;
    logic [4:0]            r_a3;
    logic [DATA_WIDTH-1:0] r_wd3;

    logic w_fifo_ne;
    logic w_pipe_valid;
    logic w_stall;
    logic w_ready;
    logic w_push;
    logic w_pop;
    logic w_pipe_sel;

    assign w_fifo_ne    = (r_count != '0);
    assign w_pipe_valid = pipe_we && (pipe_rd != 5'd0);
    assign w_stall      = !rst && (r_starve == STARVE_MAX);
    assign w_ready      = !rst && (r_count != FULL_CNT);
    // x0 results complete the handshake but are never buffered
    assign w_push       = mc_valid && w_ready && (mc_rd != 5'd0);
    // A starvation bubble lets the FIFO win even against a (contract-violating) pipe write
    assign w_pop        = w_fifo_ne && (w_stall || !w_pipe_valid);
    assign w_pipe_sel   = w_pipe_valid && !w_pop;

    assign mc_ready     = w_ready;
    assign stall_req    = w_stall;
    assign fifo_count   = r_count;
    assign write_enable = r_we;
    assign a3           = r_a3;
    assign wd3          = r_wd3;

    // FIFO storage; contents need no reset because count/pointers gate every read
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_fifo_rd[r_tail] <= mc_rd;
            r_fifo_wd[r_tail] <= mc_wd;
        end
    end

    // FIFO pointers, occupancy and starvation counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_starve <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_pop || !w_fifo_ne) begin
                r_starve <= '0;
            end else if (w_pipe_sel && (r_starve != STARVE_MAX)) begin
                r_starve <= r_starve + SW'(1);
            end else begin
                r_starve <= r_starve;
            end
        end
    end

    // Registered write port; address/data hold when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we  <= 1'b0;
            r_a3  <= 5'd0;
            r_wd3 <= '0;
        end else if (w_pop) begin
            r_we  <= 1'b1;
            r_a3  <= r_fifo_rd[r_head];
            r_wd3 <= r_fifo_wd[r_head];
        end else if (w_pipe_sel) begin
            r_we  <= 1'b1;
            r_a3  <= pipe_rd;
            r_wd3 <= pipe_wd;
        end else begin
            r_we  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Bench for reg_writeback_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_reg_writeback_arbiter;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic          clk;
    logic          rst;
    logic          pipe_we;
    logic [4:0]    pipe_rd;
    logic [DW-1:0] pipe_wd;
    logic          mc_valid;
    logic          mc_ready;
    logic [4:0]    mc_rd;
    logic [DW-1:0] mc_wd;
    logic          write_enable;
    logic [4:0]    a3;
    logic [DW-1:0] wd3;
    logic          stall_req;
    logic [2:0]    fifo_count;

    reg_writeback_arbiter #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wd(pipe_wd),
        .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_rd(mc_rd), .mc_wd(mc_wd),
        .write_enable(write_enable), .a3(a3), .wd3(wd3),
        .stall_req(stall_req), .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [36:0]   m_q[$];
    int            m_starve = 0;
    logic          m_we = 1'b0;
    logic [4:0]    m_a3 = 5'd0;
    logic [DW-1:0] m_wd = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit m_stall();
        return (m_starve == LIMIT);
    endfunction

    // one clock cycle: drive, check current outputs, advance model at the edge
    task automatic cycle(input bit r, input bit pw, input logic [4:0] prd, input logic [DW-1:0] pwd,
                         input bit mv, input logic [4:0] mrd, input logic [DW-1:0] mwd);
        bit ready, stall, pv, ne;
        @(negedge clk);
        rst = r; pipe_we = pw; pipe_rd = prd; pipe_wd = pwd;
        mc_valid = mv; mc_rd = mrd; mc_wd = mwd;
        #2;
        ready = !r && (m_q.size() != DEPTH);
        stall = !r && m_stall();
        check_eq("write_enable", {31'd0, write_enable}, {31'd0, m_we});
        check_eq("a3",           {27'd0, a3},           {27'd0, m_a3});
        check_eq("wd3",          wd3,                   m_wd);
        check_eq("fifo_count",   {29'd0, fifo_count},   m_q.size());
        check_eq("mc_ready",     {31'd0, mc_ready},     {31'd0, ready});
        check_eq("stall_req",    {31'd0, stall_req},    {31'd0, stall});
        @(posedge clk);
        if (r) begin
            m_q.delete();
            m_starve = 0;
            m_we = 1'b0; m_a3 = 5'd0; m_wd = '0;
        end else begin
            pv = pw && (prd != 5'd0);
            ne = (m_q.size() > 0);
            if (ne && (stall || !pv)) begin
                m_we = 1'b1;
                {m_a3, m_wd} = m_q.pop_front();
                m_starve = 0;
            end else if (pv) begin
                m_we = 1'b1; m_a3 = prd; m_wd = pwd;
                m_starve = ne ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
            end else begin
                m_we = 1'b0;
                m_starve = 0;
            end
            if (mv && ready && (mrd != 5'd0)) m_q.push_back({mrd, mwd});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    endtask

    initial begin
        rst = 1'b1; pipe_we = 1'b0; pipe_rd = 5'd0; pipe_wd = '0;
        mc_valid = 1'b0; mc_rd = 5'd0; mc_wd = '0;

        // 1: reset then a single pipe write
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        cycle(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, '0);
        idle(2);

        // 2: single long-latency result with idle pipe
        cycle(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd7, 32'h11);
        idle(3);

        // 3: pipe hogs the port while the FIFO fills; hazard unit honours stall_req
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 5'd1, 32'h100 + i, 1'b1, 5'd10 + i, 32'hA0 + i);
        for (int i = 0; i < 14; i++)
            cycle(1'b0, !m_stall(), 5'd1, 32'h200 + i, 1'b1, 5'd20, 32'hB0 + i);
        idle(6);

        // 4: x0 long-latency result is dropped
        cycle(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd0, 32'hFF);
        idle(2);

        // 5: pipe write to x0 lets the FIFO drain
        cycle(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'h99);
        cycle(1'b0, 1'b1, 5'd0, 32'h44, 1'b0, 5'd0, '0);
        idle(2);

        // 6: reset discards buffered entries
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 5'd2, 32'h300 + i, 1'b1, 5'd12, 32'hC0 + i);
        cycle(1'b1, 1'b1, 5'd2, 32'h3FF, 1'b1, 5'd12, 32'hCF);
        idle(4);

        // random traffic; pipe_we is withheld whenever a bubble is requested
        for (int i = 0; i < 3000; i++) begin
            bit r, pw, mv;
            logic [4:0] prd, mrd;
            r   = ($urandom_range(99, 0) == 0);
            pw  = ($urandom_range(3, 0) != 0) && !m_stall();
            prd = 5'($urandom_range(31, 0));
            mv  = ($urandom_range(2, 0) != 0);
            mrd = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
            cycle(r, pw, prd, $urandom, mv, mrd, $urandom);
        end
        idle(8);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
